// File: rtl/fu_sched_if.sv
// Issue-queue <-> functional-unit scheduler handshake bundle.
// master = issue queue side, slave = scheduler side.
interface fu_sched_if #(
  parameter int iwd = 4
);
  logic [iwd-1:0]      req_valid;
  logic [iwd-1:0][4:0] req_fu;
  logic                lsu_ready;
  logic                csr_done;
  logic                flush;
  logic [4:0]          fu_ready;
  logic [iwd-1:0]      issue;
  logic [iwd-1:0][4:0] grant_fu;
  logic [1:0]          wb_sel;

  modport master (
    output req_valid, req_fu, lsu_ready, csr_done, flush,
    input  fu_ready, issue, grant_fu, wb_sel
  );

  modport slave (
    input  req_valid, req_fu, lsu_ready, csr_done, flush,
    output fu_ready, issue, grant_fu, wb_sel
  );
endinterface

// File: rtl/fu_sched.sv
// Functional-unit scheduler: per-cycle slot arbitration over ALU/LSU/MUL/DIV/CSR
// with a reservation shift register guarding the shared MUL/DIV writeback port.
module fu_sched #(
  parameter int iwd     = 4,
  parameter int nalu    = 2,
  parameter int mul_lat = 3,
  parameter int div_lat = 16
) (
  input  logic       clk,
  input  logic       rst,
  fu_sched_if.slave  bus
);
  localparam int cw = $clog2(div_lat);

  if (!(div_lat > mul_lat && mul_lat >= 1)) begin : g_bad_lat
    $error("fu_sched: latencies must satisfy div_lat > mul_lat >= 1");
  end

  logic [div_lat:0]    wb_res_q, wb_res_d;
  logic [div_lat:0]    wb_own_q, wb_own_d;
  logic [cw-1:0]       div_cnt_q, div_cnt_d;
  logic                csr_busy_q, csr_busy_d;

  logic [4:0]          fu_ready;
  logic [iwd-1:0]      issue;
  logic [iwd-1:0][4:0] grant;
  logic [4:0]          taken;
  logic [div_lat:0]    new_res, new_own;
  logic                found;
  int                  alu_left;

  // Availability looks only at registered state and lsu_ready, never at req_*.
  always_comb begin
    fu_ready = '0;
    if (rst) begin
      fu_ready[0] = 1'b1;
      fu_ready[1] = bus.lsu_ready;
      fu_ready[2] = ~wb_res_q[mul_lat];
      fu_ready[3] = (div_cnt_q == '0) & ~wb_res_q[div_lat];
      fu_ready[4] = ~csr_busy_q;
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    issue    = '0;
    grant    = '0;
    taken    = '0;
    found    = 1'b0;
    alu_left = nalu;
    if (!bus.flush) begin
      for (int i = 0; i < iwd; i++) begin
        found = 1'b0;
        for (int f = 0; f < 5; f++) begin
          if (!found && bus.req_valid[i] && bus.req_fu[i][f] && fu_ready[f] &&
              ((f == 0) ? (alu_left > 0) : !taken[f])) begin
            found       = 1'b1;
            issue[i]    = 1'b1;
            grant[i][f] = 1'b1;
            taken[f]    = 1'b1;
            if (f == 0) alu_left = alu_left - 1;
          end
        end
      end
    end
  end

  always_comb begin
    new_res = '0;
    new_own = '0;
    if (taken[2]) new_res[mul_lat] = 1'b1;
    if (taken[3]) begin
      new_res[div_lat] = 1'b1;
      new_own[div_lat] = 1'b1;
    end
    wb_res_d = (wb_res_q | new_res) >> 1;
    wb_own_d = (wb_own_q | new_own) >> 1;

    if (taken[3])                div_cnt_d = cw'(div_lat - 1);
    else if (div_cnt_q != '0)    div_cnt_d = div_cnt_q - 1'b1;
    else                         div_cnt_d = div_cnt_q;

    // A new CSR grant wins; csr_done only matters while busy.
    if (taken[4])                csr_busy_d = 1'b1;
    else if (bus.csr_done)       csr_busy_d = 1'b0;
    else                         csr_busy_d = csr_busy_q;

    if (bus.flush) begin
      wb_res_d   = '0;
      wb_own_d   = '0;
      div_cnt_d  = '0;
      csr_busy_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_res_q   <= '0;
      wb_own_q   <= '0;
      div_cnt_q  <= '0;
      csr_busy_q <= 1'b0;
    end else begin
      wb_res_q   <= wb_res_d;
      wb_own_q   <= wb_own_d;
      div_cnt_q  <= div_cnt_d;
      csr_busy_q <= csr_busy_d;
    end
  end

  assign bus.fu_ready = fu_ready;
  assign bus.issue    = issue;
  assign bus.grant_fu = grant;
  assign bus.wb_sel   = {wb_res_q[0] & wb_own_q[0], wb_res_q[0] & ~wb_own_q[0]};

endmodule

// File: doc/fu_sched.md
FU_SCHED -- requirements
Module: fu_sched

Interface
REQ-001 SHALL have parameter iwd, default 4, meaning issue width (request/grant slots).
REQ-002 SHALL have parameter nalu, default 2, meaning ALU grants allowed per cycle.
REQ-003 SHALL have parameter mul_lat, default 3, meaning cycles from MUL grant to its shared-writeback cycle.
REQ-004 SHALL have parameter div_lat, default 16, meaning cycles from DIV grant to its shared-writeback cycle; div_lat > mul_lat >= 1 is required, else elaboration error.
REQ-005 SHALL have ports: clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  iwd  slot i holds an issue candidate.
REQ-008 req_fu  in  iwd x 5  candidate FU mask; bit0 ALU, bit1 LSU, bit2 MUL, bit3 DIV, bit4 CSR.
REQ-009 lsu_ready  in  1  LSU accepts an operation this cycle.
REQ-010 csr_done  in  1  CSR unit finished its operation.
REQ-011 flush  in  1  pipeline redirect; kill all in-flight long-latency work.
REQ-012 fu_ready  out  5  per-FU availability to the issue queue.
REQ-013 issue  out  iwd  slot i granted this cycle.
REQ-014 grant_fu  out  iwd x 5  one-hot FU selected for slot i; zero when not granted.
REQ-015 wb_sel  out  2  shared long-latency writeback port owner this cycle: 00 none, 01 MUL, 10 DIV.

Function
REQ-016 fu_ready SHALL depend only on registered state and lsu_ready, never on req_* (no combinational loop with the issue queue).
REQ-017 fu_ready[0] SHALL be 1; fu_ready[1] SHALL equal lsu_ready.
REQ-018 State: wb_res[div_lat:0] and wb_own[div_lat:0]; bit k marks shared writeback cycle (now+k) reserved, wb_own[k] = 1 for DIV.
REQ-019 fu_ready[2] SHALL be ~wb_res[mul_lat].
REQ-020 fu_ready[3] SHALL be (div_cnt == 0) & ~wb_res[div_lat]; div_cnt is a down-counter of width $clog2(div_lat).
REQ-021 fu_ready[4] SHALL be ~csr_busy.
REQ-022 Per-cycle capacity: ALU nalu, LSU 1, MUL 1, DIV 1, CSR 1, each only if its fu_ready bit is 1.
REQ-023 Arbitration in ascending slot order: slot i with req_valid[i] is granted the lowest-index FU in req_fu[i] & fu_ready with capacity remaining; capacity decremented; otherwise slot i is not granted. Grants need not be contiguous.
REQ-024 issue and grant_fu SHALL be combinational (same cycle as req_*).
REQ-025 MUL grant: set wb_res[mul_lat], wb_own[mul_lat] = 0. DIV grant: set wb_res[div_lat], wb_own[div_lat] = 1; load div_cnt = div_lat-1.
REQ-026 Each cycle: wb_res/wb_own shift right by 1 after OR-ing new reservations; div_cnt decrements while nonzero; no wrap below 0.
REQ-027 wb_sel SHALL be {wb_res[0] & wb_own[0], wb_res[0] & ~wb_own[0]}.
REQ-028 CSR grant SHALL set csr_busy next cycle; csr_done SHALL clear it next cycle; csr_done while idle is ignored.
REQ-029 flush = 1: issue = 0, grant_fu = 0 that cycle; next cycle wb_res, wb_own, div_cnt, csr_busy = 0.
REQ-030 MUL and DIV grants in the same cycle are legal (distinct reservation bits).

Reset
REQ-031 rst low SHALL clear wb_res, wb_own, div_cnt, csr_busy immediately, independent of clk.
REQ-032 While rst low: issue = 0, grant_fu = 0, fu_ready = 0, wb_sel = 00.
REQ-033 First edge after rst deasserts SHALL see fu_ready = {1, 1, 1, lsu_ready, 1}.

Verification
REQ-034 Three ALU-only requests in slots 0-2, nalu=2 -> issue = 0011, grant_fu[0] = grant_fu[1] = 00001.
REQ-035 DIV granted cycle 0 -> fu_ready[3] = 0 cycles 1-15, 1 at 16; wb_sel = 10 at 16.
REQ-036 DIV at cycle 0, MUL-only request at cycle 13 -> fu_ready[2] = 0 and no grant at 13; MUL granted at 14; wb_sel = 01 at 17.
REQ-037 CSR granted cycle 0, csr_done at 5 -> fu_ready[4] = 0 cycles 1-5, 1 at 6; second CSR request at 3 not granted.
REQ-038 DIV at cycle 0, flush at 4 -> issue = 0 at 4; fu_ready[3] = 1 and wb_sel = 00 from cycle 5; no DIV writeback at 16.
REQ-039 rst asserted mid-divide between edges -> fu_ready = 0 and issue = 0 immediately; after release, fu_ready[3] = 1, wb_sel = 00.
